// File: rtl/tap_ir_dr_if.sv
// Purpose : Pin bundle for the tap_ir_dr JTAG TAP with IR/DR chains.
// Ports   : tms/tdi        - TAP mode select and serial data in
//           tdo/tdo_en     - serial data out and its valid flag
//           state          - current TAP state code
//           ir             - active instruction
//           user_cap       - parallel value captured into the USER chain
//           user_out/stb   - last updated USER value and its update pulse
// Modports: slave drives the TAP outputs, master drives the TAP inputs.
interface tap_ir_dr_if #(
    parameter int unsigned IR_WIDTH = 4,
    parameter int unsigned DR_WIDTH = 32
);
    logic                tms;
    logic                tdi;
    logic                tdo;
    logic                tdo_en;
    logic [3:0]          state;
    logic [IR_WIDTH-1:0] ir;
    logic [DR_WIDTH-1:0] user_cap;
    logic [DR_WIDTH-1:0] user_out;
    logic                user_stb;

    modport slave (
        input  tms, tdi, user_cap,
        output tdo, tdo_en, state, ir, user_out, user_stb
    );

    modport master (
        output tms, tdi, user_cap,
        input  tdo, tdo_en, state, ir, user_out, user_stb
    );
endinterface

// File: rtl/tap_ir_dr.sv
// Purpose : IEEE 1149.1 style TAP controller with a 16-state FSM, an
//           instruction register and three data chains (BYPASS, IDCODE,
//           USER). The USER chain captures user_cap and publishes its
//           shifted contents on user_out with a one-cycle user_stb.
// Ports   : CLK   - single clock, rising edge
//           RESET - synchronous active-high reset
//           bus   - tap_ir_dr_if.slave (tms, tdi, tdo, tdo_en, state, ir,
//                   user_cap, user_out, user_stb)
module tap_ir_dr #(
    parameter int unsigned IR_WIDTH   = 4,
    parameter int unsigned DR_WIDTH   = 32,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic        CLK,
    input  logic        RESET,
    tap_ir_dr_if.slave  bus
);

    localparam int unsigned IDW = 32;

    typedef enum logic [3:0] {
        TLR    = 4'd15,
        RTI    = 4'd12,
        SEL_DR = 4'd7,
        CAP_DR = 4'd6,
        SH_DR  = 4'd2,
        EX1_DR = 4'd1,
        PAU_DR = 4'd3,
        EX2_DR = 4'd0,
        UPD_DR = 4'd5,
        SEL_IR = 4'd4,
        CAP_IR = 4'd14,
        SH_IR  = 4'd10,
        EX1_IR = 4'd9,
        PAU_IR = 4'd11,
        EX2_IR = 4'd8,
        UPD_IR = 4'd13
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] IR_USER   = IR_WIDTH'(2);

    tap_state_e          state_q,     state_d;
    logic [IR_WIDTH-1:0] ir_q,        ir_d;
    logic [IR_WIDTH-1:0] ir_sr_q,     ir_sr_d;
    logic                bypass_q,    bypass_d;
    logic [IDW-1:0]      idcode_sr_q, idcode_sr_d;
    logic [DR_WIDTH-1:0] user_sr_q,   user_sr_d;
    logic [DR_WIDTH-1:0] user_out_q,  user_out_d;
    logic                user_stb_q,  user_stb_d;

    logic                sel_idcode;
    logic                sel_user;
    logic [IR_WIDTH-1:0] ir_shift;
    logic [DR_WIDTH-1:0] user_shift;
    logic                dr_lsb;

    // Decode: IDCODE and USER explicit, everything else (incl. all-ones) is BYPASS
    assign sel_idcode = (ir_q == IR_IDCODE);
    assign sel_user   = (ir_q == IR_USER);

    // State and chain registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= TLR;
            ir_q        <= IR_IDCODE;
            ir_sr_q     <= '0;
            bypass_q    <= 1'b0;
            idcode_sr_q <= '0;
            user_sr_q   <= '0;
            user_out_q  <= '0;
            user_stb_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            ir_sr_q     <= ir_sr_d;
            bypass_q    <= bypass_d;
            idcode_sr_q <= idcode_sr_d;
            user_sr_q   <= user_sr_d;
            user_out_q  <= user_out_d;
            user_stb_q  <= user_stb_d;
        end
    end

    // TAP next-state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:     state_d = bus.tms ? TLR    : RTI;
            RTI:     state_d = bus.tms ? SEL_DR : RTI;
            SEL_DR:  state_d = bus.tms ? SEL_IR : CAP_DR;
            CAP_DR:  state_d = bus.tms ? EX1_DR : SH_DR;
            SH_DR:   state_d = bus.tms ? EX1_DR : SH_DR;
            EX1_DR:  state_d = bus.tms ? UPD_DR : PAU_DR;
            PAU_DR:  state_d = bus.tms ? EX2_DR : PAU_DR;
            EX2_DR:  state_d = bus.tms ? UPD_DR : SH_DR;
            UPD_DR:  state_d = bus.tms ? SEL_DR : RTI;
            SEL_IR:  state_d = bus.tms ? TLR    : CAP_IR;
            CAP_IR:  state_d = bus.tms ? EX1_IR : SH_IR;
            SH_IR:   state_d = bus.tms ? EX1_IR : SH_IR;
            EX1_IR:  state_d = bus.tms ? UPD_IR : PAU_IR;
            PAU_IR:  state_d = bus.tms ? EX2_IR : PAU_IR;
            EX2_IR:  state_d = bus.tms ? UPD_IR : SH_IR;
            UPD_IR:  state_d = bus.tms ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    // Register actions taken on the edge that leaves the current state
    always_comb begin
        ir_d        = ir_q;
        ir_sr_d     = ir_sr_q;
        bypass_d    = bypass_q;
        idcode_sr_d = idcode_sr_q;
        user_sr_d   = user_sr_q;
        user_out_d  = user_out_q;
        user_stb_d  = 1'b0;

        // Right shift with tdi at the MSB; written per bit so width 1 works
        ir_shift               = ir_sr_q >> 1;
        ir_shift[IR_WIDTH-1]   = bus.tdi;
        user_shift             = user_sr_q >> 1;
        user_shift[DR_WIDTH-1] = bus.tdi;

        unique case (state_q)
            TLR:    ir_d    = IR_IDCODE;
            CAP_IR: ir_sr_d = IR_WIDTH'(1);
            SH_IR:  ir_sr_d = ir_shift;
            UPD_IR: ir_d    = ir_sr_q;
            CAP_DR: begin
                if (sel_idcode)    idcode_sr_d = IDCODE_VAL;
                else if (sel_user) user_sr_d   = bus.user_cap;
                else               bypass_d    = 1'b0;
            end
            SH_DR: begin
                if (sel_idcode)    idcode_sr_d = {bus.tdi, idcode_sr_q[IDW-1:1]};
                else if (sel_user) user_sr_d   = user_shift;
                else               bypass_d    = bus.tdi;
            end
            UPD_DR: begin
                if (sel_user) begin
                    user_out_d = user_sr_q;
                    user_stb_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Serial output is combinational from the current state
    always_comb begin
        if (sel_idcode)    dr_lsb = idcode_sr_q[0];
        else if (sel_user) dr_lsb = user_sr_q[0];
        else               dr_lsb = bypass_q;
    end

    assign bus.tdo      = (state_q == SH_IR) ? ir_sr_q[0] :
                          (state_q == SH_DR) ? dr_lsb     : 1'b0;
    assign bus.tdo_en   = (state_q == SH_IR) || (state_q == SH_DR);
    assign bus.state    = state_q;
    assign bus.ir       = ir_q;
    assign bus.user_out = user_out_q;
    assign bus.user_stb = user_stb_q;

endmodule

// File: doc/tap_ir_dr.md
TAP_IR_DR -- requirements
Module: tap_ir_dr

Interface
REQ-001 The block SHALL have parameter IR_WIDTH, default 4, instruction register width, legal range 2..8.
REQ-002 The block SHALL have parameter DR_WIDTH, default 32, user data register width, legal range 1..64.
REQ-003 The block SHALL have parameter IDCODE_VAL, default 32'h1000_0001, 32-bit identification value; bit 0 SHALL be 1.
REQ-004 The block SHALL have port CLK, input, 1, single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port RESET, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port tms, input, 1, TAP mode select.
REQ-007 The block SHALL have port tdi, input, 1, serial data in.
REQ-008 The block SHALL have port tdo, output, 1, serial data out.
REQ-009 The block SHALL have port tdo_en, output, 1, high while tdo is valid.
REQ-010 The block SHALL have port state, output, 4, current TAP state code.
REQ-011 The block SHALL have port ir, output, IR_WIDTH, active instruction.
REQ-012 The block SHALL have port user_cap, input, DR_WIDTH, parallel value captured into the USER chain.
REQ-013 The block SHALL have port user_out, output, DR_WIDTH, last updated USER value.
REQ-014 The block SHALL have port user_stb, output, 1, one-cycle pulse marking a user_out update.

Function
REQ-015 The TAP SHALL use 16 states with the standard IEEE 1149.1 transitions on tms, sampled each CLK edge.
REQ-016 State codes SHALL be: TLR=15, RTI=12, SEL_DR=7, CAP_DR=6, SH_DR=2, EX1_DR=1, PAU_DR=3, EX2_DR=0, UPD_DR=5, SEL_IR=4, CAP_IR=14, SH_IR=10, EX1_IR=9, PAU_IR=11, EX2_IR=8, UPD_IR=13.
REQ-017 From any state, 5 consecutive edges with tms=1 SHALL reach TLR.
REQ-018 Instruction decode SHALL be: all-ones = BYPASS, 1 = IDCODE, 2 = USER, any other code = BYPASS.
REQ-019 Edge in CAP_IR: ir_sr SHALL load the value with bit0=1, bit1=0, and all other bits 0.
REQ-020 Edge in SH_IR: ir_sr SHALL load {tdi, ir_sr[IR_WIDTH-1:1]}, LSB first.
REQ-021 Edge in UPD_IR: ir SHALL load ir_sr; ir SHALL NOT change in any other state except TLR.
REQ-022 Edge in TLR: ir SHALL load IDCODE (value 1).
REQ-023 Edge in CAP_DR, the selected chain SHALL capture: BYPASS bit gets 0, IDCODE chain gets IDCODE_VAL, USER chain gets user_cap.
REQ-024 Edge in SH_DR, the selected chain SHALL shift right with tdi entering at the MSB.
REQ-025 Unselected chains SHALL hold their contents.
REQ-026 Edge in UPD_DR with ir=USER: user_out SHALL load the USER chain and user_stb SHALL be 1 for exactly the following cycle.
REQ-027 user_stb SHALL be 0 whenever the preceding state was not UPD_DR with ir=USER; user_out SHALL hold otherwise.
REQ-028 tdo SHALL be combinational: ir_sr[0] in SH_IR, LSB of the selected DR chain in SH_DR, and 0 otherwise.
REQ-029 tdo_en SHALL equal (state==SH_IR or state==SH_DR).
REQ-030 Pause and Exit states SHALL hold all shift registers unchanged.
REQ-031 An ir change in UPD_IR SHALL take effect at the next CAP_DR; there SHALL be no re-capture.
REQ-032 An instruction update SHALL NOT alter user_out.

Reset
REQ-033 On an edge with RESET=1, state SHALL become TLR (15), independent of tms.
REQ-034 On an edge with RESET=1, ir SHALL become 1 (IDCODE), ir_sr 0, all DR chains 0, user_out 0, and user_stb 0.
REQ-035 RESET SHALL override any shift in progress; partially shifted data SHALL be discarded and no update SHALL occur.
REQ-036 TLR via tms SHALL reset ir only; user_out SHALL be retained.

Verification
REQ-037 Reset then IDCODE: RESET 1 cycle, tms 0,1,0,0 -> state reaches SH_DR; 32 shift edges -> tdo shows 32'h1000_0001 LSB first; tdo_en high throughout SH_DR.
REQ-038 IR capture: from RTI, tms 1,1,0,0 -> in SH_IR the first tdo bits are 1,0,0,0; shifting tdi=0010 then UPD_IR -> ir=2.
REQ-039 BYPASS: load ir=4'hF, shift tdi pattern 1011 through DR -> tdo shows a leading 0 followed by 1011 delayed one cycle.
REQ-040 USER write/read: ir=2, user_cap=32'hA5A5_0F0F, shift 32'h1234_5678 in -> tdo shows A5A50F0F; after UPD_DR, user_out=32'h1234_5678 and user_stb is high for 1 cycle.
REQ-041 Reset mid-shift: RESET asserted after 10 of 32 SH_DR edges -> next cycle state=15, ir=1, user_stb=0, and user_out unchanged from 0.
REQ-042 tms walk: drive all 32 state/tms combinations -> next state matches REQ-015; 5x tms=1 from each state -> TLR.
